// File: rtl/pio_evt_pkg.sv
// Shared types for the PIO event master: FSM states, responder register map, event records.
// Build option PIO_EVT_TIMESTAMP_EN adds a timestamp field to the stored record.
package pio_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_CAP,
    RD_DATA,
    CLR,
    PUSH
  } state_t;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_EDGE = 2'd3;

  typedef struct packed {
    logic [31:0] capture;
    logic [31:0] data;
    logic [31:0] timestamp;
  } evt_rec_t;

  // Without timestamps the FIFO only stores capture and data.
`ifdef PIO_EVT_TIMESTAMP_EN
  typedef evt_rec_t evt_store_t;
`else
  typedef struct packed {
    logic [31:0] capture;
    logic [31:0] data;
  } evt_store_t;
`endif

endpackage

// File: rtl/pio_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, valid and level.
module pio_evt_fifo #(
  parameter int DEPTH = 8,
  parameter type T = logic [63:0]
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output logic                     valid,
  output T                         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  T mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   remain;
  logic [AW:0]   level_next;

  always_comb begin
    do_pop     = pop && (level != '0);
    do_push    = push && ((level != FULL_LEVEL) || do_pop);
    rd_next    = rd_ptr + AW'(do_pop);
    remain     = level - (AW+1)'(do_pop);
    level_next = remain + (AW+1)'(do_push);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // The head register is refilled from the incoming word when it lands in an otherwise empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      level  <= level_next;
      valid  <= (level_next != '0);
      if (level_next == '0)  head <= '0;
      else if (remain == '0) head <= din;
      else                   head <= mem[rd_next];
    end
  end

endmodule

// File: rtl/pio_event_master.sv
// Avalon-MM initiator that services an edge-capture PIO responder and queues event records.
// Build option PIO_EVT_TIMESTAMP_EN enables a free-running cycle stamp per event.
module pio_event_master
  import pio_evt_pkg::*;
#(
  parameter logic [31:0] IRQ_MASK   = 32'hFFFF_FFFF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            irq_in,
  output logic [1:0]                      avm_address,
  output logic                            avm_chipselect,
  output logic                            avm_write_n,
  output logic [31:0]                     avm_writedata,
  input  logic [31:0]                     avm_readdata,
  output logic                            evt_valid,
  input  logic                            evt_ready,
  output logic [31:0]                     evt_capture,
  output logic [31:0]                     evt_data,
  output logic [31:0]                     evt_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  state_t      state;
  logic [31:0] cap_r;
  logic [31:0] data_r;
  logic        push;
  evt_store_t  rec_in;
  evt_store_t  rec_head;

`ifdef PIO_EVT_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] stamp_r;

  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)                 stamp_r <= '0;
    else if (state == RD_CAP)  stamp_r <= cycle_cnt;
  end
`endif

  // Bus outputs are registered alongside the state; the read data is only ever sampled, never passed through.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT;
      busy           <= 1'b0;
      cap_r          <= '0;
      data_r         <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= REG_DATA;
      avm_writedata  <= '0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= REG_DATA;
      avm_writedata  <= '0;
      case (state)
        INIT: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= REG_MASK;
          avm_writedata  <= IRQ_MASK;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        IDLE: begin
          if (irq_in && enable && (fifo_level != FULL_LEVEL)) begin
            avm_chipselect <= 1'b1;
            avm_address    <= REG_EDGE;
            busy           <= 1'b1;
            state          <= RD_CAP;
          end else begin
            busy <= 1'b0;
          end
        end
        RD_CAP: begin
          avm_chipselect <= 1'b1;
          avm_address    <= REG_DATA;
          state          <= RD_DATA;
        end
        RD_DATA: begin
          cap_r <= avm_readdata;
          // A zero capture means a spurious interrupt, so no clear is issued.
          if (avm_readdata != '0) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= REG_EDGE;
            avm_writedata  <= avm_readdata;
          end
          state <= CLR;
        end
        CLR: begin
          data_r <= avm_readdata;
          state  <= PUSH;
        end
        PUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    push           = (state == PUSH) && (cap_r != '0);
    rec_in         = '0;
    rec_in.capture = cap_r;
    rec_in.data    = data_r;
`ifdef PIO_EVT_TIMESTAMP_EN
    rec_in.timestamp = stamp_r;
`endif
  end

  pio_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (evt_store_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec_in),
    .pop   (evt_ready),
    .valid (evt_valid),
    .head  (rec_head),
    .level (fifo_level)
  );

  assign evt_capture = rec_head.capture;
  assign evt_data    = rec_head.data;
`ifdef PIO_EVT_TIMESTAMP_EN
  assign evt_timestamp = rec_head.timestamp;
`else
  assign evt_timestamp = '0;
`endif

endmodule

// File: tb/tb_pio_event_master.sv
// Directed bench for pio_event_master with a behavioural edge-capture PIO responder.
module tb_pio_event_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        irq_in;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_capture;
  logic [31:0] evt_data;
  logic [31:0] evt_timestamp;
  logic [3:0]  fifo_level;
  logic        busy;

  logic [31:0] pins;
  logic [31:0] prev_pins;
  logic [31:0] resp_cap;
  logic [31:0] resp_mask;
  logic        force_irq;

  int test_count = 0;
  int fail_count = 0;
  int full_rd3_count = 0;
  int rd3_count = 0;

  always #5 clk = ~clk;

  pio_event_master #(
    .IRQ_MASK   (32'hFFFF_FFFF),
    .FIFO_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .irq_in         (irq_in),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_capture    (evt_capture),
    .evt_data       (evt_data),
    .evt_timestamp  (evt_timestamp),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  // Falling-edge capture responder; a clear write wins over a detect on the same bit.
  always @(posedge clk) begin
    if (reset) begin
      prev_pins    <= pins;
      resp_cap     <= '0;
      resp_mask    <= '0;
      avm_readdata <= '0;
    end else begin
      prev_pins <= pins;
      resp_cap  <= (resp_cap | (prev_pins & ~pins)) &
                   ~((avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata : 32'h0);
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2) resp_mask <= avm_writedata;
      case (avm_address)
        2'd0:    avm_readdata <= pins;
        2'd2:    avm_readdata <= resp_mask;
        2'd3:    avm_readdata <= resp_cap;
        default: avm_readdata <= '0;
      endcase
    end
  end

  assign irq_in = (|(resp_cap & resp_mask)) | force_irq;

  always @(negedge clk) begin
    if (!reset && avm_chipselect && avm_write_n && avm_address == 2'd3) begin
      rd3_count++;
      if (fifo_level == 4'd8) full_rd3_count++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic wait_rd3(input string tag);
    int n;
    n = 0;
    while (!(avm_chipselect && avm_write_n && avm_address == 2'd3) && n < 40) begin
      tick();
      n++;
    end
    check_output(tag, 32'(n < 40), 32'd1);
  endtask

  task automatic wait_level(input string tag, input logic [3:0] lvl);
    int n;
    n = 0;
    while (fifo_level != lvl && n < 40) begin
      tick();
      n++;
    end
    check_output(tag, 32'(fifo_level), 32'(lvl));
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] ts_first;
    int rd3_before;

    reset     = 1'b1;
    enable    = 1'b1;
    evt_ready = 1'b0;
    force_irq = 1'b0;
    pins      = 32'h0000_00A0;
    repeat (3) tick();

    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset chipselect", 32'(avm_chipselect), 32'd0);
    check_output("reset evt_valid", 32'(evt_valid), 32'd0);
    check_output("reset level", 32'(fifo_level), 32'd0);
    check_output("reset capture", evt_capture, 32'd0);

    reset = 1'b0;
    tick();
    check_output("init bus", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1010);
    check_output("init wdata", avm_writedata, 32'hFFFF_FFFF);
    tick();
    check_output("post-init bus idle", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b0100);
    check_output("post-init busy", 32'(busy), 32'd0);
    check_output("responder mask", resp_mask, 32'hFFFF_FFFF);

    // Single falling edge on bit 5
    pins = 32'h0000_0080;
    wait_rd3("ev1 start");
    check_output("ev1 busy", 32'(busy), 32'd1);
    tick();
    check_output("ev1 rd0", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1100);
    tick();
    check_output("ev1 wr3", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1011);
    check_output("ev1 clear data", avm_writedata, 32'h0000_0020);
    tick();
    check_output("ev1 bus idle", 32'(avm_chipselect), 32'd0);
    check_output("ev1 irq dropped", 32'(irq_in), 32'd0);
    tick();
    check_output("ev1 valid", 32'(evt_valid), 32'd1);
    check_output("ev1 capture", evt_capture, 32'h0000_0020);
    check_output("ev1 data", evt_data, 32'h0000_0080);
    check_output("ev1 level", 32'(fifo_level), 32'd1);
    check_output("ev1 done busy", 32'(busy), 32'd0);
`ifndef PIO_EVT_TIMESTAMP_EN
    check_output("ev1 timestamp", evt_timestamp, 32'd0);
`endif
    pop_one();
    check_output("ev1 popped valid", 32'(evt_valid), 32'd0);
    check_output("ev1 popped level", 32'(fifo_level), 32'd0);

    // Bit-1 edge lands during the clear of a bit-5 event
    pins = 32'h0000_00A2;
    repeat (3) tick();
    pins = 32'h0000_0082;
    wait_rd3("hz start");
    tick();
    tick();
    check_output("hz clear data", avm_writedata, 32'h0000_0020);
    pins = 32'h0000_0080;
    wait_level("hz two events", 4'd2);
    check_output("hz first capture", evt_capture, 32'h0000_0020);
    check_output("hz first data", evt_data, 32'h0000_0082);
    pop_one();
    check_output("hz second capture", evt_capture, 32'h0000_0002);
    check_output("hz second data", evt_data, 32'h0000_0080);
    check_output("hz second level", 32'(fifo_level), 32'd1);
    pop_one();
    check_output("hz drained", 32'(fifo_level), 32'd0);

    // Ten edges with no consumer
    for (int i = 0; i < 10; i++) begin
      pins = 32'h0000_0081;
      repeat (4) tick();
      pins = 32'h0000_0080;
      repeat (4) tick();
    end
    repeat (20) tick();
    check_output("full level", 32'(fifo_level), 32'd8);
    check_output("full irq held", 32'(irq_in), 32'd1);
    check_output("full no rd3", 32'(full_rd3_count), 32'd0);
    check_output("full head capture", evt_capture, 32'h0000_0001);
    pop_one();
    check_output("after pop level", 32'(fifo_level), 32'd7);
    tick();
    check_output("after pop rd3", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1111);
    repeat (6) tick();
    check_output("refill level", 32'(fifo_level), 32'd8);
    check_output("refill irq", 32'(irq_in), 32'd0);
    evt_ready = 1'b1;
    repeat (8) tick();
    evt_ready = 1'b0;
    check_output("drain level", 32'(fifo_level), 32'd0);
    check_output("drain valid", 32'(evt_valid), 32'd0);

    // Spurious interrupt, first held off by enable
    enable     = 1'b0;
    force_irq  = 1'b1;
    rd3_before = rd3_count;
    repeat (6) tick();
    check_output("disabled no service", 32'(rd3_count - rd3_before), 32'd0);
    enable = 1'b1;
    tick();
    force_irq = 1'b0;
    check_output("spur rd3", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1111);
    tick();
    check_output("spur rd0", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1100);
    tick();
    check_output("spur no write", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b0100);
    repeat (3) tick();
    check_output("spur nothing pushed", 32'(fifo_level), 32'd0);
    check_output("spur valid", 32'(evt_valid), 32'd0);
    check_output("spur single service", 32'(rd3_count - rd3_before), 32'd1);

    // Two events whose edges are 100 cycles apart
    pins = 32'h0000_0081;
    repeat (4) tick();
    pins = 32'h0000_0080;
    repeat (50) tick();
    pins = 32'h0000_0081;
    repeat (50) tick();
    pins = 32'h0000_0080;
    repeat (10) tick();
    check_output("ts two events", 32'(fifo_level), 32'd2);
    ts_first = evt_timestamp;
    pop_one();
`ifdef PIO_EVT_TIMESTAMP_EN
    check_output("ts delta", evt_timestamp - ts_first, 32'd100);
`else
    check_output("ts first zero", ts_first, 32'd0);
    check_output("ts second zero", evt_timestamp, 32'd0);
`endif
    pop_one();
    check_output("ts drained", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
